// File: rtl/msg_tx_arb_pkg.sv
// Shared types and defaults for the message transmit arbiter.
// State encoding and default gap/timeout lengths live here.
package msg_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam int SRC_W              = 2;
  localparam int DEF_GAP_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Next round-robin start position after granting idx.
  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/msg_tx_arb_pick.sv
// Combinational requester picker: fixed priority (lowest index) by default,
// round-robin starting at ptr when MSG_TX_ARB_RR_EN is defined.
module msg_tx_arb_pick
  import msg_tx_arb_pkg::*;
#(
  parameter int N_SRC = 3
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] winner,
  output logic             valid
);

`ifdef MSG_TX_ARB_RR_EN
  logic [SRC_W-1:0] idx;

  // Scan from the farthest offset down so the one closest to ptr wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      idx = SRC_W'((int'(ptr) + i) % N_SRC);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = SRC_W'(i);
        valid  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/msg_tx_arb.sv
// Shares the byte-serial line coder between up to four message controllers.
// Define MSG_TX_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module msg_tx_arb
  import msg_tx_arb_pkg::*;
#(
  parameter int N_SRC          = 3,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [N_SRC-1:0]     req,
  output logic [N_SRC-1:0]     gnt,
  input  logic [8*N_SRC-1:0]   src_q,
  input  logic [N_SRC-1:0]     src_q_rdy,
  input  logic [N_SRC-1:0]     src_msg_end,
  output logic [7:0]           cd_q,
  output logic                 cd_q_rdy,
  input  logic                 cd_busy,
  output logic                 busy,
  output logic [1:0]           cur_src,
  output logic                 abort
);

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);
  localparam logic [7:0]  GAP_LIM = 8'(GAP_CYCLES);

  arb_state_e       state_q, state_d;
  logic [N_SRC-1:0] gnt_q, gnt_d;
  logic [SRC_W-1:0] cur_src_q, cur_src_d;
  logic             busy_q, busy_d;
  logic             abort_q, abort_d;
  logic [15:0]      tmo_cnt_q, tmo_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] pick_w;
  logic             pick_valid;
  logic [15:0]      tmo_next;
  logic             timeout;
  logic [7:0]       src_byte [N_SRC];
  logic             sel_rdy, sel_end, sel_req;

`ifdef MSG_TX_ARB_RR_EN
  logic [SRC_W-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign src_byte[g] = src_q[8*g +: 8];
  end

  assign sel_rdy = src_q_rdy[cur_src_q];
  assign sel_end = src_msg_end[cur_src_q];
  assign sel_req = req[cur_src_q];

  msg_tx_arb_pick #(.N_SRC(N_SRC)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_w),
    .valid  (pick_valid)
  );

  // Coder input follows the granted source only while a grant is held.
  always_comb begin
    cd_q     = '0;
    cd_q_rdy = 1'b0;
    if (state_q == ST_GRANT) begin
      cd_q     = src_byte[cur_src_q];
      cd_q_rdy = sel_rdy;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cur_src_d = cur_src_q;
    busy_d    = busy_q;
    abort_d   = 1'b0;
    tmo_cnt_d = tmo_cnt_q;
    gap_cnt_d = gap_cnt_q;
`ifdef MSG_TX_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    tmo_next  = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
    if (sel_rdy) tmo_next = '0;
    timeout   = (tmo_next >= TMO_LIM);

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d         = ST_GRANT;
          gnt_d           = '0;
          gnt_d[pick_w]   = 1'b1;
          cur_src_d       = pick_w;
          busy_d          = 1'b1;
          tmo_cnt_d       = '0;
`ifdef MSG_TX_ARB_RR_EN
          ptr_d           = wrap_inc(pick_w, N_SRC);
`endif
        end
      end
      ST_GRANT: begin
        tmo_cnt_d = tmo_next;
        if (sel_end || !sel_req || timeout) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          gap_cnt_d = '0;
          abort_d   = timeout && !sel_end && sel_req;
        end
      end
      ST_GAP: begin
        // Only consecutive quiet coder cycles count towards the gap.
        if (cd_busy) begin
          gap_cnt_d = '0;
        end else if ((gap_cnt_q + 8'd1) >= GAP_LIM) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      cur_src_q <= '0;
      busy_q    <= 1'b0;
      abort_q   <= 1'b0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
`ifdef MSG_TX_ARB_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cur_src_q <= cur_src_d;
      busy_q    <= busy_d;
      abort_q   <= abort_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef MSG_TX_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign cur_src = cur_src_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_msg_tx_arb.sv
// Self-checking bench for msg_tx_arb: vector table, directed corner sequences
// and a randomized run against a behavioural model of the arbitration rules.
module tb_msg_tx_arb;

  localparam int N   = 3;
  localparam int GAP = 4;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [2:0]   req, src_q_rdy, src_msg_end;
  logic [23:0]  src_q;
  logic         cd_busy;
  logic [2:0]   gnt;
  logic [7:0]   cd_q;
  logic         cd_q_rdy, busy, abort;
  logic [1:0]   cur_src;

  int n_checks = 0;
  int n_fail   = 0;

  msg_tx_arb #(.N_SRC(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .req         (req),
    .gnt         (gnt),
    .src_q       (src_q),
    .src_q_rdy   (src_q_rdy),
    .src_msg_end (src_msg_end),
    .cd_q        (cd_q),
    .cd_q_rdy    (cd_q_rdy),
    .cd_busy     (cd_busy),
    .busy        (busy),
    .cur_src     (cur_src),
    .abort       (abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  rdy;
    logic [2:0]  mend;
    logic [23:0] sq;
    logic [2:0]  e_gnt;
    logic        e_busy;
    logic        e_abort;
    logic        e_rdy;
    logic [7:0]  e_q;
    logic [1:0]  e_cur;
  } vec_t;

  vec_t tbl [13];

  // Behavioural model: who owns the coder, whether we are waiting out a gap.
  bit m_active, m_gap, m_abort;
  int m_owner, m_last, m_start, m_quiet, m_silent;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_now(input string tag, input logic [2:0] e_gnt, input logic e_busy,
                           input logic e_abort, input logic e_rdy, input logic [7:0] e_q,
                           input logic [1:0] e_cur);
    chk({tag, " gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, " busy"}, 32'(busy), 32'(e_busy));
    chk({tag, " abort"}, 32'(abort), 32'(e_abort));
    chk({tag, " cd_q_rdy"}, 32'(cd_q_rdy), 32'(e_rdy));
    chk({tag, " cd_q"}, 32'(cd_q), 32'(e_q));
    chk({tag, " cur_src"}, 32'(cur_src), 32'(e_cur));
  endtask

  task automatic check_output(input string tag, input logic [2:0] e_gnt, input logic e_busy,
                              input logic e_abort, input logic e_rdy, input logic [7:0] e_q,
                              input logic [1:0] e_cur);
    @(negedge clk);
    check_now(tag, e_gnt, e_busy, e_abort, e_rdy, e_q, e_cur);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_active = 0; m_gap = 0; m_abort = 0;
    m_owner = 0; m_last = 0; m_start = 0; m_quiet = 0; m_silent = 0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    req = '0; src_q_rdy = '0; src_msg_end = '0; src_q = '0; cd_busy = 1'b0;
    #3;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic model_step();
    bit to;
    bit nxt_abort;
    nxt_abort = 0;
    if (m_active) begin
      m_silent = src_q_rdy[m_owner] ? 0 : m_silent + 1;
      to = (m_silent >= TMO);
      if (src_msg_end[m_owner] || !req[m_owner] || to) begin
        nxt_abort = to && !src_msg_end[m_owner] && req[m_owner];
        m_active = 0;
        m_gap = 1;
        m_quiet = 0;
      end
    end else if (m_gap) begin
      m_quiet = cd_busy ? 0 : m_quiet + 1;
      if (m_quiet >= GAP) m_gap = 0;
    end else if (req != 0) begin
      for (int k = N - 1; k >= 0; k--) begin
`ifdef MSG_TX_ARB_RR_EN
        if (req[(m_start + k) % N]) m_owner = (m_start + k) % N;
`else
        if (req[k]) m_owner = k;
`endif
      end
      m_last = m_owner;
      m_active = 1;
      m_silent = 0;
`ifdef MSG_TX_ARB_RR_EN
      m_start = (m_owner + 1) % N;
`endif
    end
    m_abort = nxt_abort;
  endtask

  task automatic model_check(input int cyc);
    logic [2:0] e_gnt;
    logic [7:0] e_q;
    logic       e_rdy;
    string      tag;
    e_gnt = m_active ? 3'(1 << m_owner) : 3'b000;
    e_q   = m_active ? src_q[8*m_owner +: 8] : 8'h00;
    e_rdy = m_active ? src_q_rdy[m_owner] : 1'b0;
    tag   = $sformatf("rand%0d", cyc);
    check_now(tag, e_gnt, m_active || m_gap, m_abort, e_rdy, e_q, 2'(m_last));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [4];
    int waited;

    // Vector table: grant src 1 over src 2, message end, 4-cycle gap, then src 2.
    tbl[0]  = '{3'b110, 3'b000, 3'b000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{3'b110, 3'b010, 3'b000, 24'h003C00, 3'b010, 1'b1, 1'b0, 1'b1, 8'h3C, 2'd1};
    tbl[2]  = '{3'b110, 3'b001, 3'b000, 24'h001177, 3'b010, 1'b1, 1'b0, 1'b0, 8'h11, 2'd1};
    tbl[3]  = '{3'b110, 3'b000, 3'b010, 24'h002200, 3'b010, 1'b1, 1'b0, 1'b0, 8'h22, 2'd1};
    tbl[4]  = '{3'b100, 3'b000, 3'b000, 24'hABCDEF, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd1};
    tbl[5]  = '{3'b100, 3'b110, 3'b000, 24'hABCDEF, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd1};
    tbl[6]  = '{3'b100, 3'b000, 3'b000, 24'hABCDEF, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd1};
    tbl[7]  = '{3'b100, 3'b000, 3'b000, 24'hABCDEF, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd1};
    tbl[8]  = '{3'b100, 3'b000, 3'b000, 24'hABCDEF, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1};
    tbl[9]  = '{3'b100, 3'b000, 3'b000, 24'h000000, 3'b100, 1'b1, 1'b0, 1'b0, 8'h00, 2'd2};
    tbl[10] = '{3'b100, 3'b101, 3'b000, 24'h5A0099, 3'b100, 1'b1, 1'b0, 1'b1, 8'h5A, 2'd2};
    tbl[11] = '{3'b000, 3'b000, 3'b000, 24'h000000, 3'b100, 1'b1, 1'b0, 1'b0, 8'h00, 2'd2};
    tbl[12] = '{3'b000, 3'b000, 3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd2};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req; src_q_rdy = tbl[i].rdy; src_msg_end = tbl[i].mend; src_q = tbl[i].sq;
      check_output($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_busy, tbl[i].e_abort,
                   tbl[i].e_rdy, tbl[i].e_q, tbl[i].e_cur);
    end

    // Byte mux: only the granted source's strobe reaches the coder.
    do_reset();
    req = 3'b001;
    check_output("mux idle", 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    src_q = 24'h0000A5; src_q_rdy = 3'b001;
    check_output("mux a5", 3'b001, 1'b1, 1'b0, 1'b1, 8'hA5, 2'd0);
    src_q = 24'hFF00A5; src_q_rdy = 3'b100;
    check_output("mux other", 3'b001, 1'b1, 1'b0, 1'b0, 8'hA5, 2'd0);

    // Timeout abort, then a gap stretched by a busy coder.
    do_reset();
    req = 3'b001;
    check_output("to idle", 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    for (int k = 1; k <= TMO; k++)
      check_output($sformatf("to grant%0d", k), 3'b001, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
    req = 3'b000; cd_busy = 1'b1;
    check_output("to abort", 3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
    for (int k = 0; k < 9; k++)
      check_output($sformatf("gap busy%0d", k), 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
    cd_busy = 1'b0;
    for (int k = 0; k < GAP; k++)
      check_output($sformatf("gap quiet%0d", k), 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
    check_output("gap done", 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);

    // Asynchronous reset while source 1 is streaming.
    do_reset();
    req = 3'b010;
    check_output("rst idle0", 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    src_q = 24'h004200; src_q_rdy = 3'b010;
    check_output("rst stream", 3'b010, 1'b1, 1'b0, 1'b1, 8'h42, 2'd1);
    #2;
    n_rst = 1'b0;
    #1;
    check_now("rst async", 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    check_output("rst release", 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    check_output("rst regrant", 3'b010, 1'b1, 1'b0, 1'b1, 8'h42, 2'd1);

    // All sources held requesting, four-byte messages each.
`ifdef MSG_TX_ARB_RR_EN
    exp_order = '{0, 1, 2, 0};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    do_reset();
    req = 3'b111;
    for (int m = 0; m < 4; m++) begin
      waited = 0;
      while (gnt == 3'b000 && waited < 20) begin
        @(posedge clk);
        #1;
        waited++;
      end
      chk($sformatf("seq%0d gnt", m), 32'(gnt), 32'(1 << exp_order[m]));
      chk($sformatf("seq%0d cur_src", m), 32'(cur_src), 32'(exp_order[m]));
      if (m > 0) chk($sformatf("seq%0d gap", m), 32'(waited), 32'(GAP + 1));
      for (int b = 0; b < 4; b++) begin
        src_q       = {3{8'(16 * m + b)}};
        src_q_rdy   = 3'(1 << exp_order[m]);
        src_msg_end = (b == 3) ? 3'(1 << exp_order[m]) : 3'b000;
        @(negedge clk);
        chk($sformatf("seq%0d byte%0d rdy", m, b), 32'(cd_q_rdy), 32'd1);
        chk($sformatf("seq%0d byte%0d q", m, b), 32'(cd_q), 32'(16 * m + b));
        @(posedge clk);
        #1;
      end
      src_q_rdy = '0; src_msg_end = '0;
    end

    // Randomized traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) req[i] = ($urandom_range(3) == 0);
        else if ($urandom_range(15) == 0) req[i] = 1'b0;
        src_q_rdy[i]   = ($urandom_range(1) == 0);
        src_msg_end[i] = ($urandom_range(5) == 0);
      end
      src_q   = 24'($urandom);
      cd_busy = ($urandom_range(2) == 0);
      @(negedge clk);
      model_check(cyc);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_tx_arb.md
# msg_tx_arb

Arbiter and sequencer sharing the single byte-serial line coder between up to four message controllers (control command word, data word, status word, etc.). Grants the coder to one requester per message and multiplexes its byte stream onto the coder input. Releases the grant at message end, enforces an inter-message idle gap, and drops a stalled grant with an abort pulse. Sits between the per-message controllers and the coder.

## Interface
- N_SRC, 3, number of requesters, legal 2..4
- GAP_CYCLES, 4, idle cycles with cd_busy low required between messages, legal 1..255
- TIMEOUT_CYCLES, 1024, max cycles in GRANT without a src_q_rdy pulse before abort, legal 2..65535

- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- req  in  N_SRC  per-source message pending, level, held until message end
- gnt  out  N_SRC  one-hot grant, registered; drives the source's tx_rdy
- src_q  in  8*N_SRC  source bytes, source i on bits [8i+7:8i]
- src_q_rdy  in  N_SRC  per-source byte strobe
- src_msg_end  in  N_SRC  per-source message-end indication
- cd_q  out  8  byte to coder
- cd_q_rdy  out  1  byte strobe to coder
- cd_busy  in  1  coder serialising a byte
- busy  out  1  arbiter not in IDLE
- cur_src  out  2  index of granted/last-granted source
- abort  out  1  one-cycle pulse on timeout release

## Operation
- States: IDLE, GRANT, GAP.
- IDLE: if req != 0, picker selects winner w; next edge gnt = 1<<w, cur_src = w, go GRANT. req == 0: stay.
- GRANT: cd_q = src_q[w]; cd_q_rdy = src_q_rdy[w]. Sources other than w are ignored entirely.
- GRANT exits to GAP on first of: src_msg_end[w]; req[w] low; timeout counter reaching TIMEOUT_CYCLES (abort = 1 that cycle's edge for one cycle). gnt cleared on the same edge.
- Timeout counter: 16 bit, cleared on entering GRANT and on every src_q_rdy[w]; saturates, never wraps.
- GAP: gap counter (8 bit) cleared on entry, increments each cycle cd_busy low, clears when cd_busy high. Reaching GAP_CYCLES -> IDLE.
- Outside GRANT: cd_q = 0, cd_q_rdy = 0.
- Simultaneous msg_end and new req in GRANT: GAP taken regardless; new req considered only in IDLE.
- req of other sources asserted/deasserted during GRANT/GAP: no effect until IDLE.
- Reset (any state, asynchronous): state IDLE, gnt 0, cd_q 0, cd_q_rdy 0, busy 0, cur_src 0, abort 0, counters 0, priority pointer 0.

## Timing
- req to gnt: 1 clk (decision combinational in IDLE, gnt registered).
- src_q/src_q_rdy to cd_q/cd_q_rdy: 0 clk, combinational mux from registered select.
- msg_end to gnt low: 1 clk edge; minimum gnt-low time = GAP_CYCLES + 1 cycles.
- busy high from the edge entering GRANT until the edge entering IDLE.
- abort high exactly one cycle, coincident with first GAP cycle.
- Back-to-back requests of the same source: separated by GAP.

## Configuration
- MSG_TX_ARB_RR_EN defined: round-robin; pointer p updated to (w+1) mod N_SRC on each grant; search starts at p, wraps.
- Not defined: fixed priority, lowest index wins; pointer logic absent.

## Structure
- State encodings (IDLE=0, GRANT=1, GAP=2) and default GAP_CYCLES/TIMEOUT_CYCLES constants in src/code/vh/msg_defs.vh alongside the existing marker/flag defines.
- One sub-module: msg_tx_arb_pick — combinational picker, inputs req, pointer, output winner index and valid; contains the MSG_TX_ARB_RR_EN conditional.

## Test plan
- Reset mid-GRANT (src 1 streaming) -> gnt=0, cd_q_rdy=0, cur_src=0 immediately, IDLE after release.
- req=3'b110, fixed priority -> gnt=3'b010 one cycle later; src_msg_end[1] -> gnt=0, GAP 4 cycles, then gnt=3'b100.
- MSG_TX_ARB_RR_EN, req=3'b111 held, each source ends after 4 bytes -> grant order 0,1,2,0.
- GRANT src 0, src_q=8'hA5 with src_q_rdy pulse -> cd_q=8'hA5, cd_q_rdy same cycle; src_q_rdy[2] pulse -> cd_q_rdy stays 0.
- TIMEOUT_CYCLES=8, granted source never strobes -> abort pulse one cycle at 8th cycle, gnt cleared.
- cd_busy held high 10 cycles in GAP -> IDLE only after GAP_CYCLES consecutive low cycles.
